// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_pkg
//  Brief    : Shared constants and helpers for the programmable clock divider.
//  Revision : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int C_DEFAULT_HP = 50_000_000;
    localparam int C_TICK_CNT_W = 16;

    // Channel-select width; a single channel still needs a 1-bit select.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_prog_if.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_prog_if
//  Brief    : Valid/ready half-period configuration port of clk_div_prog.
//  Revision : 1.0 - initial release
// ============================================================================
interface clk_div_prog_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 26
);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_hp;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_hp,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_hp,
        output cfg_ready, cfg_err
    );

endinterface
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_chan
//  Brief    : One 50%-duty divider channel with deferred half-period reload.
//             CLKDIV_TICK_CNT_EN adds a 16-bit rising-edge counter output.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W      = 26,
    parameter int DEFAULT_HP = C_DEFAULT_HP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_hp,
`ifdef CLKDIV_TICK_CNT_EN
    output logic [C_TICK_CNT_W-1:0] tick_cnt,
`endif
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hp;
    logic [CNT_W-1:0] r_pend_hp;
    logic             r_pending;
    logic             r_clk_out;
    logic             r_tick;

    logic             w_terminal;
    logic             w_apply;

    assign w_terminal = (r_cnt == (r_hp - CNT_W'(1)));
    // A stored update only lands where a half-period boundary begins anyway.
    assign w_apply    = r_pending && (sync_clr || !en || w_terminal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_hp      <= CNT_W'(DEFAULT_HP);
            r_pend_hp <= '0;
            r_pending <= 1'b0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            if (sync_clr || !en) begin
                r_cnt     <= '0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
            end else if (w_terminal) begin
                r_cnt     <= '0;
                r_clk_out <= ~r_clk_out;
                r_tick    <= 1'b1;
            end else begin
                r_cnt     <= r_cnt + CNT_W'(1);
                r_tick    <= 1'b0;
            end

            // load is only granted while nothing is pending, so it never meets w_apply.
            if (w_apply) begin
                r_hp      <= r_pend_hp;
                r_pending <= 1'b0;
            end else if (load) begin
                r_pend_hp <= load_hp;
                r_pending <= 1'b1;
            end
        end
    end

`ifdef CLKDIV_TICK_CNT_EN
    logic [C_TICK_CNT_W-1:0] r_tick_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (sync_clr) begin
            r_tick_cnt <= '0;
        end else if (en && w_terminal && !r_clk_out) begin
            r_tick_cnt <= r_tick_cnt + C_TICK_CNT_W'(1);
        end
    end

    assign tick_cnt = r_tick_cnt;
`endif

    assign pending = r_pending;
    assign clk_out = r_clk_out;
    assign tick    = r_tick;

endmodule
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_prog
//  Brief    : Multi-channel programmable clock divider with valid/ready config.
//             CLKDIV_TICK_CNT_EN adds per-channel tick_cnt outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 26,
    parameter int DEFAULT_HP = C_DEFAULT_HP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_clr,
    clk_div_prog_if.slave     cfg,
`ifdef CLKDIV_TICK_CNT_EN
    output logic [NUM_CH*C_TICK_CNT_W-1:0] tick_cnt,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam int CH_W    = ch_width(NUM_CH);
    localparam int CH_SPAN = 1 << CH_W;

    logic [NUM_CH-1:0]  w_pending;
    logic [NUM_CH-1:0]  w_load;
    logic [CH_SPAN-1:0] w_pend_span;
    logic               w_ch_ok;
    logic               w_hp_ok;
    logic               w_fire;
    logic               w_accept;
    logic               r_cfg_err;

    // Unused select codes read as not-pending so bad channels are rejected, not stalled.
    always_comb begin
        w_pend_span               = '0;
        w_pend_span[NUM_CH-1:0]   = w_pending;
    end

    assign cfg.cfg_ready = ~w_pend_span[cfg.cfg_ch];
    assign w_ch_ok       = ({1'b0, cfg.cfg_ch} < (CH_W+1)'(NUM_CH));
    assign w_hp_ok       = |cfg.cfg_hp;
    assign w_fire        = cfg.cfg_valid & cfg.cfg_ready;
    assign w_accept      = w_fire & w_ch_ok & w_hp_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_fire & ~(w_ch_ok & w_hp_ok);
        end
    end

    assign cfg.cfg_err = r_cfg_err;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign w_load[i] = w_accept && (cfg.cfg_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W      (CNT_W),
            .DEFAULT_HP (DEFAULT_HP)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en[i]),
            .sync_clr (sync_clr),
            .load     (w_load[i]),
            .load_hp  (cfg.cfg_hp),
`ifdef CLKDIV_TICK_CNT_EN
            .tick_cnt (tick_cnt[i*C_TICK_CNT_W +: C_TICK_CNT_W]),
`endif
            .pending  (w_pending[i]),
            .clk_out  (clk_out[i]),
            .tick     (tick[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_div_prog
//  Brief    : Directed self-checking bench for clk_div_prog (4 ch, 8-bit, hp 3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int CHW = 2;
    localparam int DHP = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           sync_clr;
    logic [NCH-1:0] en;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
`ifdef CLKDIV_TICK_CNT_EN
    logic [NCH*16-1:0] tick_cnt;
`endif

    clk_div_prog_if #(.CH_W(CHW), .CNT_W(CW)) cfg_if ();

    clk_div_prog #(
        .NUM_CH     (NCH),
        .CNT_W      (CW),
        .DEFAULT_HP (DHP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync_clr (sync_clr),
        .cfg      (cfg_if.slave),
`ifdef CLKDIV_TICK_CNT_EN
        .tick_cnt (tick_cnt),
`endif
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: each channel counts cycles elapsed in its current half-period (age)
    // and flips its level once age reaches the half-period length.
    int m_hp   [NCH];
    int m_pend [NCH];   // 0 means no update waiting
    int m_age  [NCH];
    int m_tcnt [NCH];
    bit m_lvl  [NCH];
    bit m_tick [NCH];
    bit m_err;

    always @(posedge clk) begin
        int ch;
        int req;
        bit rdy;
        bit fire;
        bit acc;
        bit rej;
        logic [NCH-1:0] e_clk;
        logic [NCH-1:0] e_tick;
        bit e_rdy;
        #1;
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_hp[c] = DHP; m_pend[c] = 0; m_age[c] = 0;
                m_tcnt[c] = 0; m_lvl[c] = 0; m_tick[c] = 0;
            end
            m_err = 0;
        end else begin
            ch   = int'(cfg_if.cfg_ch);
            req  = int'(cfg_if.cfg_hp);
            rdy  = (ch >= NCH) || (m_pend[ch] == 0);
            fire = cfg_if.cfg_valid && rdy;
            rej  = fire && (req == 0 || ch >= NCH);
            acc  = fire && !rej;
            m_err = rej;
            for (int c = 0; c < NCH; c++) begin
                if (sync_clr || !en[c]) begin
                    m_lvl[c] = 0; m_tick[c] = 0; m_age[c] = 0;
                    if (sync_clr) m_tcnt[c] = 0;
                    if (m_pend[c] != 0) begin m_hp[c] = m_pend[c]; m_pend[c] = 0; end
                end else begin
                    m_age[c] = m_age[c] + 1;
                    if (m_age[c] == m_hp[c]) begin
                        m_age[c]  = 0;
                        m_tick[c] = 1;
                        if (!m_lvl[c]) m_tcnt[c] = (m_tcnt[c] + 1) % 65536;
                        m_lvl[c]  = !m_lvl[c];
                        if (m_pend[c] != 0) begin m_hp[c] = m_pend[c]; m_pend[c] = 0; end
                    end else begin
                        m_tick[c] = 0;
                    end
                end
                if (acc && ch == c) m_pend[c] = req;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            e_clk[c]  = m_lvl[c];
            e_tick[c] = m_tick[c];
        end
        ch    = int'(cfg_if.cfg_ch);
        e_rdy = (ch >= NCH) || (m_pend[ch] == 0);
        check("model clk_out", 32'(clk_out), 32'(e_clk));
        check("model tick", 32'(tick), 32'(e_tick));
        check("model cfg_err", 32'(cfg_if.cfg_err), 32'(m_err));
        check("model cfg_ready", 32'(cfg_if.cfg_ready), 32'(e_rdy));
`ifdef CLKDIV_TICK_CNT_EN
        for (int c = 0; c < NCH; c++)
            check("model tick_cnt", 32'(tick_cnt[c*16 +: 16]), 32'(m_tcnt[c]));
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        en               = '0;
        sync_clr         = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_hp    = '0;
        step(3);
        check("reset clk_out", 32'(clk_out), 32'h0);
        check("reset tick", 32'(tick), 32'h0);
        check("reset cfg_ready", 32'(cfg_if.cfg_ready), 32'h1);
        check("reset cfg_err", 32'(cfg_if.cfg_err), 32'h0);

        // First rise on the 3rd edge, period 6
        rst_n = 1'b1;
        en    = 4'b0001;
        step(2);
        check("t1 no rise by edge 2", 32'(clk_out[0]), 32'h0);
        step(1);
        check("t1 rise edge 3", 32'(clk_out[0]), 32'h1);
        check("t1 tick edge 3", 32'(tick[0]), 32'h1);
        step(1);
        check("t1 tick one cycle", 32'(tick[0]), 32'h0);
        step(2);
        check("t1 fall edge 6", 32'(clk_out[0]), 32'h0);
        check("t1 others idle", 32'(clk_out[3:1]), 32'h0);

        // Mid-run reload keeps the current half-period; second request stalls
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'd0;
        cfg_if.cfg_hp    = 8'd5;
        step(1);
        check("t2 stall while pending", 32'(cfg_if.cfg_ready), 32'h0);
        cfg_if.cfg_hp = 8'd7;
        step(2);
        check("t2 old half-period", 32'(clk_out[0]), 32'h1);
        check("t2 ready after apply", 32'(cfg_if.cfg_ready), 32'h1);
        step(1);
        check("t2 second accepted", 32'(cfg_if.cfg_ready), 32'h0);
        cfg_if.cfg_valid = 1'b0;
        step(3);
        check("t2 hp5 not yet", 32'(clk_out[0]), 32'h1);
        step(1);
        check("t2 hp5 toggle", 32'(clk_out[0]), 32'h0);

        // Rejected zero half-period, then hp=1 on a disabled channel
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'd1;
        cfg_if.cfg_hp    = 8'd0;
        step(1);
        check("t3 err pulse", 32'(cfg_if.cfg_err), 32'h1);
        cfg_if.cfg_ch = 2'd2;
        cfg_if.cfg_hp = 8'd1;
        step(1);
        check("t3 err one cycle", 32'(cfg_if.cfg_err), 32'h0);
        cfg_if.cfg_valid = 1'b0;
        step(1);
        en = 4'b0101;
        step(1);
        check("t3 hp1 high", 32'({clk_out[2], tick[2]}), 32'h3);
        step(1);
        check("t3 hp1 low", 32'({clk_out[2], tick[2]}), 32'h1);

        // Accept coincident with terminal count
        en = 4'b1101;
        step(2);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'd3;
        cfg_if.cfg_hp    = 8'd4;
        step(1);
        check("t4 toggle old hp", 32'({clk_out[3], tick[3]}), 32'h3);
        cfg_if.cfg_valid = 1'b0;
        step(3);
        check("t4 next still old hp", 32'({clk_out[3], tick[3]}), 32'h1);
        step(3);
        check("t4 hp4 no toggle at 3", 32'({clk_out[3], tick[3]}), 32'h0);
        step(1);
        check("t4 hp4 toggle", 32'({clk_out[3], tick[3]}), 32'h3);

        // sync_clr phase-aligns hp 3/4/7 channels
        en = 4'b1111;
        step(2);
        sync_clr = 1'b1;
        step(1);
        check("t5 clr clk_out", 32'(clk_out), 32'h0);
        check("t5 clr tick", 32'(tick), 32'h0);
        sync_clr = 1'b0;
        step(3);
        check("t5 hp3 rise", 32'({clk_out[1], tick[1]}), 32'h3);
        step(1);
        check("t5 hp4 rise", 32'({clk_out[3], tick[3]}), 32'h3);
        step(2);
        check("t5 hp7 not yet", 32'(clk_out[0]), 32'h0);
        step(1);
        check("t5 hp7 rise", 32'(clk_out[0]), 32'h1);

        // Asynchronous reset between edges
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 async clk_out", 32'(clk_out), 32'h0);
        check("t6 async tick", 32'(tick), 32'h0);
        check("t6 async ready", 32'(cfg_if.cfg_ready), 32'h1);
        step(1);
        rst_n = 1'b1;
        en    = 4'b0001;
        step(2);
        check("t6 default hp no rise", 32'(clk_out[0]), 32'h0);
        step(1);
        check("t6 default hp rise", 32'(clk_out[0]), 32'h1);
`ifdef CLKDIV_TICK_CNT_EN
        check("t6 tick_cnt after reset", 32'(tick_cnt[15:0]), 32'h1);
`endif
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
